// File: rtl/mem_stream_packer.sv
// rtl/mem_stream_packer.sv - packs fixed-size records into an AXI4-Stream byte stream
module mem_stream_packer #(
    parameter int REC_BYTES = 23,
    parameter int DW_BYTES  = 8,
    parameter int CNT_W     = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [REC_BYTES*8-1:0] rec_data,
    input  logic                   rec_valid,
    input  logic                   rec_last,
    output logic                   rec_ready,
    output logic [DW_BYTES*8-1:0]  m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic [DW_BYTES-1:0]    m_tkeep,
    output logic [DW_BYTES-1:0]    m_tstrb,
    output logic [CNT_W-1:0]       rec_cnt,
    output logic [CNT_W-1:0]       pkt_cnt
);

    localparam int BUF_BYTES = REC_BYTES + DW_BYTES - 1;
    localparam int CW        = $clog2(BUF_BYTES + 1);
    localparam logic [CW-1:0] DW_C  = CW'(DW_BYTES);
    localparam logic [CW-1:0] REC_C = CW'(REC_BYTES);

    logic [BUF_BYTES*8-1:0] data_buf_q, data_buf_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   flush_q, flush_d;
    logic [DW_BYTES-1:0]    keep;
    logic                   rec_acc;
    logic                   beat;

    // All stream outputs decode from registered state only.
    always_comb begin
        rec_ready = !flush_q && (cnt_q < DW_C);
        m_tvalid  = (cnt_q >= DW_C) || (flush_q && (cnt_q != '0));
        m_tlast   = flush_q && (cnt_q <= DW_C);
        keep      = '0;
        m_tdata   = '0;
        for (int i = 0; i < DW_BYTES; i++) begin
            keep[i] = (i < int'(cnt_q));
            if (keep[i]) begin
                m_tdata[i*8 +: 8] = data_buf_q[i*8 +: 8];
            end
        end
        m_tkeep = keep;
        m_tstrb = keep;
    end

    always_comb begin
        data_buf_d = data_buf_q;
        cnt_d      = cnt_q;
        flush_d    = flush_q;
        rec_acc    = rec_valid && rec_ready;
        beat       = m_tvalid && m_tready;
        if (rec_acc) begin
            // Append the record just above the bytes already held.
            for (int i = 0; i < BUF_BYTES; i++) begin
                if ((i >= int'(cnt_q)) && (i < int'(cnt_q) + REC_BYTES)) begin
                    data_buf_d[i*8 +: 8] = rec_data[(i - int'(cnt_q))*8 +: 8];
                end
            end
            cnt_d   = cnt_q + REC_C;
            flush_d = rec_last;
        end else if (beat) begin
            data_buf_d = data_buf_q >> (DW_BYTES*8);
            if (m_tlast) begin
                cnt_d   = '0;
                flush_d = 1'b0;
            end else begin
                cnt_d = cnt_q - DW_C;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_buf_q <= '0;
            cnt_q      <= '0;
            flush_q    <= 1'b0;
            rec_cnt    <= '0;
            pkt_cnt    <= '0;
        end else begin
            data_buf_q <= data_buf_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            if (rec_acc) begin
                rec_cnt <= rec_cnt + 1'b1;
            end
            if (beat && m_tlast) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stream_packer.sv
// tb/tb_mem_stream_packer.sv - randomized bench for mem_stream_packer against a byte-queue model
module tb_mem_stream_packer;

    localparam int REC = 23;
    localparam int DW  = 8;
    localparam int CW  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [REC*8-1:0]  rec_data;
    logic              rec_valid;
    logic              rec_last;
    logic              rec_ready;
    logic [DW*8-1:0]   m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic [DW-1:0]     m_tkeep;
    logic [DW-1:0]     m_tstrb;
    logic [CW-1:0]     rec_cnt;
    logic [CW-1:0]     pkt_cnt;

    mem_stream_packer #(
        .REC_BYTES(REC),
        .DW_BYTES (DW),
        .CNT_W    (CW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rec_data (rec_data),
        .rec_valid(rec_valid),
        .rec_last (rec_last),
        .rec_ready(rec_ready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .m_tkeep  (m_tkeep),
        .m_tstrb  (m_tstrb),
        .rec_cnt  (rec_cnt),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [REC*8-1:0] send_data[$];
    bit               send_last[$];
    logic [7:0]       pend[$];
    logic [DW*8-1:0]  exp_data[$];
    logic [DW-1:0]    exp_keep[$];
    bit               exp_last[$];
    logic [CW-1:0]    m_rec = '0;
    logic [CW-1:0]    m_pkt = '0;
    int               valid_pct = 100;
    int               ready_pct = 100;
    bit               stalled = 1'b0;
    bit               acc_prev = 1'b0;
    logic [DW*8-1:0]  p_data;
    logic [DW-1:0]    p_keep;
    logic             p_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [REC*8-1:0] rand_rec();
        logic [REC*8-1:0] r;
        for (int j = 0; j < REC; j++) r[j*8 +: 8] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    function automatic logic [REC*8-1:0] mk_rec(input int base);
        logic [REC*8-1:0] r;
        for (int j = 0; j < REC; j++) r[j*8 +: 8] = 8'(base + j);
        return r;
    endfunction

    // Cut the pending packet bytes into the next expected beat.
    task automatic emit(input bit pkt_end);
        logic [DW*8-1:0] d;
        logic [DW-1:0]   k;
        int              n;
        d = '0;
        k = '0;
        n = (pend.size() < DW) ? pend.size() : DW;
        for (int b = 0; b < n; b++) begin
            d[b*8 +: 8] = pend.pop_front();
            k[b] = 1'b1;
        end
        exp_data.push_back(d);
        exp_keep.push_back(k);
        exp_last.push_back(pkt_end && (pend.size() == 0));
    endtask

    task automatic model_accept(input logic [REC*8-1:0] d, input bit last);
        for (int j = 0; j < REC; j++) pend.push_back(d[j*8 +: 8]);
        m_rec++;
        if (last) begin
            while (pend.size() > 0) emit(1'b1);
        end else begin
            while (pend.size() >= DW) emit(1'b0);
        end
    endtask

    task automatic step();
        bit empty_exp;
        empty_exp = (exp_data.size() == 0);
        check("tvalid", m_tvalid, !empty_exp);
        check("rec_ready", rec_ready, empty_exp);
        check("ready_and_valid", m_tvalid & rec_ready, 0);
        check("rec_cnt", rec_cnt, m_rec);
        check("pkt_cnt", pkt_cnt, m_pkt);
        if (acc_prev) check("latency_tvalid", m_tvalid, 1);
        if (stalled) begin
            check("stall_tvalid", m_tvalid, 1);
            check("stall_tdata", m_tdata, p_data);
            check("stall_tkeep", m_tkeep, p_keep);
            check("stall_tlast", m_tlast, p_last);
        end
        if (!m_tvalid) check("idle_tlast", m_tlast, 0);
        if (m_tvalid && !empty_exp) begin
            check("tdata", m_tdata, exp_data[0]);
            check("tkeep", m_tkeep, exp_keep[0]);
            check("tstrb", m_tstrb, exp_keep[0]);
            check("tlast", m_tlast, exp_last[0]);
        end
        rec_valid = (send_data.size() > 0) && ($urandom_range(0, 99) < valid_pct);
        if (rec_valid) begin
            rec_data = send_data[0];
            rec_last = send_last[0];
        end else begin
            rec_data = rand_rec();
            rec_last = 1'($urandom_range(0, 1));
        end
        m_tready = ($urandom_range(0, 99) < ready_pct);
        acc_prev = rec_valid && rec_ready;
        if (acc_prev) model_accept(send_data.pop_front(), send_last.pop_front());
        if (m_tvalid && m_tready && !empty_exp) begin
            if (exp_last[0]) m_pkt++;
            void'(exp_data.pop_front());
            void'(exp_keep.pop_front());
            void'(exp_last.pop_front());
        end
        stalled = m_tvalid && !m_tready;
        p_data  = m_tdata;
        p_keep  = m_tkeep;
        p_last  = m_tlast;
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int max);
        int n;
        n = 0;
        while ((send_data.size() > 0 || exp_data.size() > 0) && n < max) begin
            step();
            n++;
        end
        check("drain", send_data.size() + exp_data.size(), 0);
        step();
        step();
    endtask

    // A record is offered during reset to confirm reset wins over the accept.
    task automatic do_reset();
        reset_n   = 1'b0;
        rec_valid = 1'b1;
        rec_data  = rand_rec();
        rec_last  = 1'b1;
        m_tready  = 1'b1;
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        rec_valid = 1'b0;
        m_tready  = 1'b0;
        send_data.delete();
        send_last.delete();
        pend.delete();
        exp_data.delete();
        exp_keep.delete();
        exp_last.delete();
        m_rec    = '0;
        m_pkt    = '0;
        stalled  = 1'b0;
        acc_prev = 1'b0;
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_tkeep", m_tkeep, 0);
        check("rst_tstrb", m_tstrb, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_rec_ready", rec_ready, 1);
        check("rst_rec_cnt", rec_cnt, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
    endtask

    initial begin
        int n;
        int nrec;
        reset_n   = 1'b0;
        rec_valid = 1'b0;
        rec_last  = 1'b0;
        rec_data  = '0;
        m_tready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // single 23-byte packet of bytes 00..16
        valid_pct = 100;
        ready_pct = 100;
        send_data.push_back(mk_rec(0));
        send_last.push_back(1'b1);
        run_idle(50);
        check("t1_pkt_cnt", pkt_cnt, 1);
        check("t1_rec_cnt", rec_cnt, 1);

        // two records forming a 46-byte packet
        send_data.push_back(mk_rec(0));
        send_last.push_back(1'b0);
        send_data.push_back(mk_rec(23));
        send_last.push_back(1'b1);
        run_idle(50);

        // hold m_tready low for 10 cycles with a beat pending
        send_data.push_back(mk_rec(8'h40));
        send_last.push_back(1'b1);
        ready_pct = 0;
        n = 0;
        while (send_data.size() > 0 && n < 20) begin
            step();
            n++;
        end
        repeat (10) step();
        ready_pct = 100;
        run_idle(50);

        // random traffic with random back-pressure and gaps
        valid_pct = 70;
        ready_pct = 60;
        for (int p = 0; p < 40; p++) begin
            nrec = $urandom_range(1, 6);
            for (int r = 0; r < nrec; r++) begin
                send_data.push_back(rand_rec());
                send_last.push_back(r == nrec - 1);
            end
        end
        run_idle(20000);

        // 8 x 23 = 184 bytes: packet ends on a full beat
        valid_pct = 100;
        ready_pct = 100;
        for (int r = 0; r < 8; r++) begin
            send_data.push_back(rand_rec());
            send_last.push_back(r == 7);
        end
        run_idle(200);

        // reset right after the first beat of a packet
        do_reset();
        send_data.push_back(mk_rec(0));
        send_last.push_back(1'b1);
        n = 0;
        while (!(send_data.size() == 0 && exp_data.size() == 2) && n < 20) begin
            step();
            n++;
        end
        check("mid_first_beat", exp_data.size(), 2);
        do_reset();
        send_data.push_back(mk_rec(8'h80));
        send_last.push_back(1'b1);
        run_idle(50);

        // 16 records wrap the 4-bit record counter back to 0
        do_reset();
        ready_pct = 70;
        for (int r = 0; r < 16; r++) begin
            send_data.push_back(rand_rec());
            send_last.push_back((r % 4) == 3);
        end
        run_idle(2000);
        check("wrap_rec_cnt", rec_cnt, 0);
        check("wrap_pkt_cnt", pkt_cnt, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
